// File: rtl/fp_mul_arbiter.sv
// Shares one single-precision multiplier among NREQ requesters, one multiplication in flight.
// Define FP_MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; round-robin otherwise.
module fp_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_stb,
    output logic [NREQ-1:0]    req_ack,
    output logic [31:0]        rsp_z,
    output logic [NREQ-1:0]    rsp_stb,
    input  logic [NREQ-1:0]    rsp_ack,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    output logic               mul_ab_stb,
    input  logic               mul_ab_ack,
    input  logic [31:0]        mul_z,
    input  logic               mul_z_stb,
    output logic               mul_z_ack,
    output logic               busy,
    output logic [IDW-1:0]     grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RETURN} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic [NREQ-1:0]   rsp_stb_q, rsp_stb_d;
    logic [31:0]       rsp_z_q, rsp_z_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic              mul_ab_stb_q, mul_ab_stb_d;
    logic              mul_z_ack_q, mul_z_ack_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   search_vec;
    logic [IDW-1:0]    win;

    function automatic logic [IDW-1:0] lowest_set(input logic [NREQ-1:0] v);
        lowest_set = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDW'(i);
        end
    endfunction

    function automatic logic [NREQ-1:0] one_hot(input logic [IDW-1:0] g);
        for (int i = 0; i < NREQ; i++) begin
            one_hot[i] = (g == IDW'(i));
        end
    endfunction

    // Round-robin: prefer requests at or above the pointer, else wrap to the lowest index.
    always_comb begin
        search_vec = req_stb;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            search_vec[i] = req_stb[i] && (IDW'(i) >= ptr_q);
        end
        if (search_vec == '0) search_vec = req_stb;
`endif
        win = lowest_set(search_vec);
    end

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        req_ack_d    = '0;
        rsp_stb_d    = rsp_stb_q;
        rsp_z_d      = rsp_z_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_ab_stb_d = mul_ab_stb_q;
        mul_z_ack_d  = mul_z_ack_q;

        case (state_q)
            IDLE: begin
                if (|req_stb) begin
                    state_d      = ISSUE;
                    grant_id_d   = win;
                    req_ack_d    = one_hot(win);
                    mul_ab_stb_d = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == IDW'(i)) begin
                            mul_a_d = req_a[32*i +: 32];
                            mul_b_d = req_b[32*i +: 32];
                        end
                    end
                end
            end
            ISSUE: begin
                if (mul_ab_stb_q && mul_ab_ack) begin
                    mul_ab_stb_d = 1'b0;
                    mul_z_ack_d  = 1'b1;
                    state_d      = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (mul_z_stb && mul_z_ack_q) begin
                    rsp_z_d     = mul_z;
                    mul_z_ack_d = 1'b0;
                    rsp_stb_d   = one_hot(grant_id_q);
                    state_d     = RETURN;
                end
            end
            RETURN: begin
                // rsp_stb_q is one-hot on the grant, so acks on other lines mask out.
                if (|(rsp_stb_q & rsp_ack)) begin
                    rsp_stb_d = '0;
                    state_d   = IDLE;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
                    ptr_d     = '0;
`else
                    ptr_d     = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            req_ack_q    <= '0;
            rsp_stb_q    <= '0;
            rsp_z_q      <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_ab_stb_q <= 1'b0;
            mul_z_ack_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            req_ack_q    <= req_ack_d;
            rsp_stb_q    <= rsp_stb_d;
            rsp_z_q      <= rsp_z_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_ab_stb_q <= mul_ab_stb_d;
            mul_z_ack_q  <= mul_z_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign rsp_stb    = rsp_stb_q;
    assign rsp_z      = rsp_z_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_ab_stb = mul_ab_stb_q;
    assign mul_z_ack  = mul_z_ack_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one single-precision multiplier; legal range 2..8.
REQ-002 Parameter IDW, default 3, width of grant_id; SHALL satisfy 2^IDW >= NREQ.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  clock, all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_a  in  NREQ*32  operand A per requester; slice i is [32*i+31:32*i].
REQ-007 req_b  in  NREQ*32  operand B per requester, same slicing.
REQ-008 req_stb  in  NREQ  request valid; held until the matching req_ack is seen.
REQ-009 req_ack  out  NREQ  operand-accept pulse, one-hot or zero.
REQ-010 rsp_z  out  32  result, shared by all requesters.
REQ-011 rsp_stb  out  NREQ  result valid, one-hot or zero.
REQ-012 rsp_ack  in  NREQ  result accept.
REQ-013 mul_a, mul_b  out  32 each  operands to the multiplier.
REQ-014 mul_ab_stb  out  1 and mul_ab_ack  in  1  multiplier operand handshake.
REQ-015 mul_z  in  32, mul_z_stb  in  1 and mul_z_ack  out  1  multiplier result handshake.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 grant_id  out  IDW  index of the current or last granted requester.

Function
REQ-018 All handshakes SHALL transfer on a cycle where stb and ack are both high; all outputs are registered.
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT_Z and RETURN, with at most one multiplication in flight.
REQ-020 IDLE: when any req_stb is high, the arbiter SHALL select winner g, latch its operands and grant_id<=g, drive req_ack[g]=1 for exactly one cycle, and move to ISSUE.
REQ-021 ISSUE: mul_ab_stb=1 with latched operands; on mul_ab_stb&&mul_ab_ack it SHALL drop mul_ab_stb and move to WAIT_Z.
REQ-022 WAIT_Z: mul_z_ack=1; on mul_z_stb&&mul_z_ack it SHALL latch mul_z into rsp_z, drop mul_z_ack and move to RETURN.
REQ-023 RETURN: rsp_stb[g]=1 and rsp_z held stable; on rsp_stb[g]&&rsp_ack[g] it SHALL clear rsp_stb, update the priority pointer and return to IDLE.
REQ-024 Default arbitration is round-robin: search from pointer p upward modulo NREQ, with p<=g+1 after each completed RETURN; NREQ-1 wraps to 0.
REQ-025 Requests arriving while busy SHALL wait; no req_ack is issued outside IDLE.
REQ-026 rsp_ack on non-granted lines and mul_z_stb outside WAIT_Z SHALL be ignored.
REQ-027 Minimum latency from req_stb to rsp_stb is 3 cycles plus multiplier latency; IDLE-to-IDLE throughput is one request per transaction.
REQ-028 Operands and results SHALL pass through bit-exact; the arbiter performs no arithmetic.

Reset
REQ-029 On rst the block SHALL enter IDLE with pointer 0, grant_id 0, and req_ack, rsp_stb, mul_ab_stb, mul_z_ack and busy all 0; rsp_z, mul_a and mul_b are cleared to 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction without any response; rst SHALL be shared with the multiplier so that both restart together.

Configuration
REQ-031 Macro FP_MUL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and the pointer is unused and held at 0; undefined: round-robin per REQ-024.

Verification
REQ-032 Single request: req_stb[0], a=0x40000000, b=0x40400000 -> req_ack[0] pulses once, then rsp_stb[0]=1 with rsp_z=0x40C00000, and all other rsp_stb lines stay 0.
REQ-033 After reset, all four req_stb held with requester i operands 0x3FC00000 x 0x3FC00000 -> grants 0,1,2,3 in order, each rsp_z=0x40100000; with FIXED_PRIO_EN and req0 re-asserting immediately, req0 is granted every time.
REQ-034 Backpressure: rsp_ack[1] held low for 10 cycles -> rsp_stb[1] and rsp_z stable, busy=1, and no req_ack issued until the accept cycle.
REQ-035 Wrap: last grant 3, with req0 and req2 pending -> req0 granted first, then req2.
REQ-036 rst asserted in WAIT_Z -> next cycle all strobes and acks 0 with busy=0, and a following request 2.0x3.0 returns 0x40C00000.
